// File: rtl/mem_arbiter_pkg.sv
// Shared widths, state encoding and helpers for the unified memory bus arbiter.
package mem_arbiter_pkg;

  localparam int XLEN    = 64;
  localparam int BE_W    = XLEN / 8;
  localparam int IWORD_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_DATA  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  // Fetches always move a whole doubleword; the slot is picked on return.
  function automatic logic [XLEN-1:0] fetch_addr(input logic [XLEN-1:0] addr);
    return addr & ~{{(XLEN-3){1'b0}}, 3'b111};
  endfunction

  // Upper word when the fetch address had bit 2 set, lower word otherwise.
  function automatic logic [IWORD_W-1:0] fetch_word(input logic [XLEN-1:0] rdata,
                                                    input logic           sel_hi);
    return sel_hi ? rdata[XLEN-1:IWORD_W] : rdata[IWORD_W-1:0];
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request/response and bus-side signals of the memory arbiter.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic               imemReq;
  logic [XLEN-1:0]    imemAddr;
  logic [IWORD_W-1:0] imemRdata;
  logic               imemValid;
  logic               imemFault;

  logic               dmemReq;
  logic               dmemWe;
  logic [XLEN-1:0]    dmemAddr;
  logic [XLEN-1:0]    dmemWdata;
  logic [BE_W-1:0]    dmemBe;
  logic [XLEN-1:0]    dmemRdata;
  logic               dmemValid;
  logic               dmemFault;

  logic               busReq;
  logic               busWe;
  logic [XLEN-1:0]    busAddr;
  logic [XLEN-1:0]    busWdata;
  logic [BE_W-1:0]    busBe;
  logic [XLEN-1:0]    busRdata;
  logic               busReady;

  logic               stallIF;
  logic               stallMEM;

  // The arbiter's own view.
  modport master (
    input  imemReq, imemAddr, dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe,
    input  busRdata, busReady,
    output imemRdata, imemValid, imemFault, dmemRdata, dmemValid, dmemFault,
    output busReq, busWe, busAddr, busWdata, busBe, stallIF, stallMEM
  );

  // Everything around the arbiter: pipeline requesters and the bus slave.
  modport slave (
    output imemReq, imemAddr, dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe,
    output busRdata, busReady,
    input  imemRdata, imemValid, imemFault, dmemRdata, dmemValid, dmemFault,
    input  busReq, busWe, busAddr, busWdata, busBe, stallIF, stallMEM
  );

endinterface

// File: rtl/mem_arbiter_watchdog.sv
// Bus watchdog: counts cycles a transaction has been on the bus.
module mem_arbiter_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] TC = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_cnt;

  // Clear wins over count so a new grant always starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != TC)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Terminal count is only meaningful while a transaction is on the bus.
  assign o_tc = i_en && (r_cnt == TC);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single memory bus between instruction fetch and data
// access, one transaction at a time, with a watchdog and fetch anti-starvation.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master arb
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e         r_state;
  logic               r_busReq;
  logic               r_busWe;
  logic [XLEN-1:0]    r_busAddr;
  logic [XLEN-1:0]    r_busWdata;
  logic [BE_W-1:0]    r_busBe;
  logic               r_fetchHi;
  logic [IWORD_W-1:0] r_imemRdata;
  logic [XLEN-1:0]    r_dmemRdata;
  logic               r_imemValid;
  logic               r_dmemValid;
  logic               r_imemFault;
  logic               r_dmemFault;
  logic [SW-1:0]      r_starveCnt;

  logic w_grantData;
  logic w_grantFetch;
  logic w_onBus;
  logic w_wdTc;

  function automatic logic [SW-1:0] starve_inc(input logic [SW-1:0] v);
    return (v == STARVE_MAX) ? v : v + 1'b1;
  endfunction

  // Data normally wins a tie; a fetch that has lost STARVE_LIMIT times wins.
  assign w_grantData  = (r_state == ARB_IDLE) && arb.dmemReq &&
                        !(arb.imemReq && (r_starveCnt == STARVE_MAX));
  assign w_grantFetch = (r_state == ARB_IDLE) && arb.imemReq && !w_grantData;
  assign w_onBus      = (r_state == ARB_FETCH) || (r_state == ARB_DATA);

  mem_arbiter_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .i_clear(w_grantData || w_grantFetch),
    .i_en   (w_onBus),
    .o_tc   (w_wdTc)
  );

  // Transaction sequencer: grant, hold the bus, capture or time out, complete.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_busReq    <= 1'b0;
      r_busWe     <= 1'b0;
      r_busAddr   <= '0;
      r_busWdata  <= '0;
      r_busBe     <= '0;
      r_fetchHi   <= 1'b0;
      r_imemRdata <= '0;
      r_dmemRdata <= '0;
      r_imemValid <= 1'b0;
      r_dmemValid <= 1'b0;
      r_imemFault <= 1'b0;
      r_dmemFault <= 1'b0;
      r_starveCnt <= '0;
    end else begin
      r_imemValid <= 1'b0;
      r_dmemValid <= 1'b0;
      r_imemFault <= 1'b0;
      r_dmemFault <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_grantData) begin
            r_busReq    <= 1'b1;
            r_busWe     <= arb.dmemWe;
            r_busAddr   <= arb.dmemAddr;
            r_busWdata  <= arb.dmemWdata;
            r_busBe     <= arb.dmemBe;
            r_starveCnt <= arb.imemReq ? starve_inc(r_starveCnt) : '0;
            r_state     <= ARB_DATA;
          end else if (w_grantFetch) begin
            r_busReq    <= 1'b1;
            r_busWe     <= 1'b0;
            r_busAddr   <= fetch_addr(arb.imemAddr);
            r_busWdata  <= '0;
            r_busBe     <= {BE_W{1'b1}};
            r_fetchHi   <= arb.imemAddr[2];
            r_starveCnt <= '0;
            r_state     <= ARB_FETCH;
          end
        end
        ARB_FETCH: begin
          if (arb.busReady) begin
            r_imemRdata <= fetch_word(arb.busRdata, r_fetchHi);
            r_imemValid <= 1'b1;
            r_busReq    <= 1'b0;
            r_state     <= ARB_DONE;
          end else if (w_wdTc) begin
            r_imemRdata <= '0;
            r_imemValid <= 1'b1;
            r_imemFault <= 1'b1;
            r_busReq    <= 1'b0;
            r_state     <= ARB_DONE;
          end
        end
        ARB_DATA: begin
          if (arb.busReady) begin
            r_dmemRdata <= arb.busRdata;
            r_dmemValid <= 1'b1;
            r_busReq    <= 1'b0;
            r_state     <= ARB_DONE;
          end else if (w_wdTc) begin
            r_dmemRdata <= '0;
            r_dmemValid <= 1'b1;
            r_dmemFault <= 1'b1;
            r_busReq    <= 1'b0;
            r_state     <= ARB_DONE;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign arb.busReq    = r_busReq;
  assign arb.busWe     = r_busWe;
  assign arb.busAddr   = r_busAddr;
  assign arb.busWdata  = r_busWdata;
  assign arb.busBe     = r_busBe;
  assign arb.imemRdata = r_imemRdata;
  assign arb.imemValid = r_imemValid;
  assign arb.imemFault = r_imemFault;
  assign arb.dmemRdata = r_dmemRdata;
  assign arb.dmemValid = r_dmemValid;
  assign arb.dmemFault = r_dmemFault;

  // A requester stays stalled from request until its completion pulse.
  assign arb.stallIF  = arb.imemReq & ~r_imemValid;
  assign arb.stallMEM = arb.dmemReq & ~r_dmemValid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int TO = 8;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if ifc();

  mem_arbiter #(.TIMEOUT_CYCLES(TO), .STARVE_LIMIT(SL)) dut (
    .clk  (clk),
    .reset(reset),
    .arb  (ifc)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Slave model: ready after slv_wait bus cycles (-1 = never).
  int          slv_wait = 0;
  int          slv_cnt  = 0;
  bit          slv_rand = 0;
  bit          slv_stray = 0;
  logic [63:0] slv_data = '0;

  initial begin
    int w;
    ifc.busReady = 1'b0;
    ifc.busRdata = '0;
    forever begin
      @(negedge clk);
      if (ifc.busReq === 1'b1) begin
        if (slv_cnt == 0 && slv_rand) begin
          w = $urandom_range(0, 9);
          slv_wait = (w < 6) ? (w % 4) : ((w == 6) ? TO - 1 : -1);
          slv_data = {$urandom, $urandom};
        end
        if (slv_cnt == slv_wait) begin
          ifc.busReady = 1'b1;
          ifc.busRdata = slv_data;
        end else begin
          ifc.busReady = 1'b0;
          ifc.busRdata = {$urandom, $urandom};
        end
        slv_cnt++;
      end else begin
        slv_cnt = 0;
        ifc.busReady = slv_stray ? 1'($urandom_range(0, 1)) : 1'b0;
        ifc.busRdata = {$urandom, $urandom};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  task automatic idle_inputs();
    ifc.imemReq   = 1'b0;
    ifc.imemAddr  = '0;
    ifc.dmemReq   = 1'b0;
    ifc.dmemWe    = 1'b0;
    ifc.dmemAddr  = '0;
    ifc.dmemWdata = '0;
    ifc.dmemBe    = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    slv_rand = 0; slv_stray = 0; slv_wait = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({ifc.busReq, ifc.busWe, ifc.busAddr, ifc.busWdata, ifc.busBe} !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: req=%b we=%b addr=%h wdata=%h be=%h required all 0",
               ifc.busReq, ifc.busWe, ifc.busAddr, ifc.busWdata, ifc.busBe);
    end
    n_cmp++;
    if ({ifc.imemValid, ifc.dmemValid, ifc.imemFault, ifc.dmemFault} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: iv=%b dv=%b if=%b df=%b required 0",
               ifc.imemValid, ifc.dmemValid, ifc.imemFault, ifc.dmemFault);
    end
    n_cmp++;
    if ({ifc.imemRdata, ifc.dmemRdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_rdata: i=%h d=%h required 0", ifc.imemRdata, ifc.dmemRdata);
    end
    n_cmp++;
    if ({ifc.stallIF, ifc.stallMEM} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_stall: %b%b required 00", ifc.stallIF, ifc.stallMEM);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (ifc.busReq !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_request: busReq=%b required 0", ifc.busReq);
    end
  endtask

  task automatic test_fetch_alone();
    int lat, buscyc;
    bit got;
    lat = 0; buscyc = 0; got = 0;
    slv_rand = 0; slv_stray = 0; slv_wait = 2; slv_data = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge clk); #1;
    ifc.imemAddr = 64'h1004;
    ifc.imemReq  = 1'b1;
    #1;
    n_cmp++;
    if (ifc.stallIF !== 1'b1) begin
      n_fail++; $display("FAIL fetch_stall_req: stallIF=%b required 1", ifc.stallIF);
    end
    while (!got && lat < 20) begin
      @(negedge clk); #1; lat++;
      if (ifc.imemValid === 1'b1) got = 1;
      else begin
        n_cmp++;
        if (ifc.stallIF !== 1'b1) begin
          n_fail++; $display("FAIL fetch_stall_wait: cycle %0d stallIF=%b required 1", lat, ifc.stallIF);
        end
        if (ifc.busReq === 1'b1) begin
          buscyc++;
          n_cmp++;
          if ({ifc.busWe, ifc.busAddr, ifc.busBe} !== {1'b0, 64'h1000, 8'hFF}) begin
            n_fail++;
            $display("FAIL fetch_bus_fields: we=%b addr=%h be=%h required 0/1000/ff",
                     ifc.busWe, ifc.busAddr, ifc.busBe);
          end
        end
      end
    end
    n_cmp++;
    if (!got || lat != 4 || buscyc != 3) begin
      n_fail++; $display("FAIL fetch_latency: got=%0d lat=%0d buscyc=%0d required 1/4/3", got, lat, buscyc);
    end
    n_cmp++;
    if ({ifc.imemRdata, ifc.imemFault, ifc.stallIF, ifc.busReq} !== {32'hAAAABBBB, 3'b000}) begin
      n_fail++;
      $display("FAIL fetch_result: rdata=%h fault=%b stall=%b busReq=%b required aaaabbbb/0/0/0",
               ifc.imemRdata, ifc.imemFault, ifc.stallIF, ifc.busReq);
    end
    ifc.imemReq = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if ({ifc.imemValid, ifc.imemRdata} !== {1'b0, 32'hAAAABBBB}) begin
      n_fail++; $display("FAIL fetch_pulse_hold: valid=%b rdata=%h required 0/aaaabbbb", ifc.imemValid, ifc.imemRdata);
    end
  endtask

  task automatic test_store_alone();
    int lat, buscyc;
    bit got;
    lat = 0; buscyc = 0; got = 0;
    slv_rand = 0; slv_stray = 0; slv_wait = 0; slv_data = 64'h0;
    @(negedge clk); #1;
    ifc.dmemWe = 1'b1; ifc.dmemAddr = 64'h2008; ifc.dmemBe = 8'h0F;
    ifc.dmemWdata = 64'h1122_3344_5566_7788; ifc.dmemReq = 1'b1;
    while (!got && lat < 20) begin
      @(negedge clk); #1; lat++;
      if (ifc.dmemValid === 1'b1) got = 1;
      else if (ifc.busReq === 1'b1) begin
        buscyc++;
        n_cmp++;
        if ({ifc.busWe, ifc.busAddr, ifc.busWdata, ifc.busBe} !==
            {1'b1, 64'h2008, 64'h1122_3344_5566_7788, 8'h0F}) begin
          n_fail++;
          $display("FAIL store_bus_fields: we=%b addr=%h wdata=%h be=%h", ifc.busWe, ifc.busAddr, ifc.busWdata, ifc.busBe);
        end
      end
    end
    // Valid lands in the third cycle counting the request cycle.
    n_cmp++;
    if (!got || lat != 2 || buscyc != 1 || ifc.dmemFault !== 1'b0) begin
      n_fail++;
      $display("FAIL store_latency: got=%0d lat=%0d buscyc=%0d fault=%b required 1/2/1/0", got, lat, buscyc, ifc.dmemFault);
    end
    ifc.dmemReq = 1'b0; ifc.dmemWe = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_starvation();
    logic [9:0] seen, want;
    int ncomp, guard;
    seen = '0; want = '0; ncomp = 0; guard = 0;
    for (int i = 0; i < 10; i++) want[i] = ((i % (SL + 1)) == SL);
    slv_rand = 0; slv_stray = 0; slv_wait = 0; slv_data = 64'h0BAD_F00D_1234_5678;
    @(negedge clk); #1;
    ifc.imemAddr = 64'h0; ifc.imemReq = 1'b1;
    ifc.dmemWe = 1'b0; ifc.dmemAddr = 64'h100; ifc.dmemReq = 1'b1;
    while ((ifc.imemReq || ifc.dmemReq) && guard < 200) begin
      @(negedge clk); #1; guard++;
      if (ifc.imemValid === 1'b1 && ifc.dmemValid === 1'b1) begin
        n_cmp++; n_fail++; $display("FAIL starve_double_valid: both valids at cycle %0d", guard);
      end
      if (ifc.imemValid === 1'b1 || ifc.dmemValid === 1'b1) begin
        if (ncomp < 10) seen[ncomp] = ifc.imemValid;
        ncomp++;
        if (ncomp >= 10) begin
          if (ifc.imemValid === 1'b1) ifc.imemReq = 1'b0;
          if (ifc.dmemValid === 1'b1) ifc.dmemReq = 1'b0;
        end
      end
    end
    n_cmp++;
    if (seen !== want || guard >= 200) begin
      n_fail++;
      $display("FAIL starve_sequence: fetch-grant bits (lsb first) %b required %b, cycles=%0d", seen, want, guard);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int lat, buscyc;
    bit got;
    slv_rand = 0; slv_stray = 0;
    // Prime dmemRdata with a non-zero load so the forced zero is visible.
    slv_wait = 1; slv_data = 64'h5A5A_5A5A_1234_5678;
    lat = 0; got = 0;
    @(negedge clk); #1;
    ifc.dmemWe = 1'b0; ifc.dmemAddr = 64'h3000; ifc.dmemReq = 1'b1;
    while (!got && lat < 20) begin
      @(negedge clk); #1; lat++;
      if (ifc.dmemValid === 1'b1) got = 1;
    end
    n_cmp++;
    if (!got || ifc.dmemRdata !== 64'h5A5A_5A5A_1234_5678 || ifc.dmemFault !== 1'b0) begin
      n_fail++; $display("FAIL load_data: got=%0d rdata=%h fault=%b required 1/5a5a5a5a12345678/0", got, ifc.dmemRdata, ifc.dmemFault);
    end
    ifc.dmemReq = 1'b0;
    @(negedge clk); #1;
    slv_wait = -1;
    lat = 0; buscyc = 0; got = 0;
    ifc.dmemAddr = 64'h3010; ifc.dmemReq = 1'b1;
    while (!got && lat < 40) begin
      @(negedge clk); #1; lat++;
      if (ifc.dmemValid === 1'b1) got = 1;
      else if (ifc.busReq === 1'b1) buscyc++;
    end
    n_cmp++;
    if (!got || buscyc != TO) begin
      n_fail++; $display("FAIL timeout_cycles: got=%0d bus cycles=%0d required 1/%0d", got, buscyc, TO);
    end
    n_cmp++;
    if ({ifc.dmemFault, ifc.dmemRdata, ifc.busReq} !== {1'b1, 64'h0, 1'b0}) begin
      n_fail++; $display("FAIL timeout_result: fault=%b rdata=%h busReq=%b required 1/0/0", ifc.dmemFault, ifc.dmemRdata, ifc.busReq);
    end
    ifc.dmemReq = 1'b0;
    @(negedge clk); #1;
    slv_wait = 0; slv_data = 64'h0123_4567_89AB_CDEF;
    lat = 0; got = 0;
    ifc.imemAddr = 64'h40; ifc.imemReq = 1'b1;
    while (!got && lat < 20) begin
      @(negedge clk); #1; lat++;
      if (ifc.imemValid === 1'b1) got = 1;
    end
    n_cmp++;
    if (!got || lat != 2 || ifc.imemFault !== 1'b0 || ifc.imemRdata !== 32'h89AB_CDEF) begin
      n_fail++;
      $display("FAIL fetch_after_timeout: got=%0d lat=%0d fault=%b rdata=%h required 1/2/0/89abcdef", got, lat, ifc.imemFault, ifc.imemRdata);
    end
    ifc.imemReq = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_terminal_ready();
    int lat, buscyc;
    bit got;
    lat = 0; buscyc = 0; got = 0;
    slv_rand = 0; slv_stray = 0; slv_wait = TO - 1; slv_data = 64'hFEED_FACE_CAFE_BEEF;
    @(negedge clk); #1;
    ifc.dmemWe = 1'b0; ifc.dmemAddr = 64'h3800; ifc.dmemReq = 1'b1;
    while (!got && lat < 40) begin
      @(negedge clk); #1; lat++;
      if (ifc.dmemValid === 1'b1) got = 1;
      else if (ifc.busReq === 1'b1) buscyc++;
    end
    n_cmp++;
    if (!got || buscyc != TO || ifc.dmemFault !== 1'b0 || ifc.dmemRdata !== 64'hFEED_FACE_CAFE_BEEF) begin
      n_fail++;
      $display("FAIL ready_on_terminal: got=%0d buscyc=%0d fault=%b rdata=%h required 1/%0d/0/feedfacecafebeef",
               got, buscyc, ifc.dmemFault, ifc.dmemRdata, TO);
    end
    ifc.dmemReq = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    bit got, addr_ok;
    lat = 0; got = 0; addr_ok = 0;
    slv_rand = 0; slv_stray = 0; slv_wait = -1; slv_data = 64'h7777_6666_5555_4444;
    @(negedge clk); #1;
    ifc.dmemWe = 1'b0; ifc.dmemAddr = 64'h4000; ifc.dmemReq = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (ifc.busReq !== 1'b1) begin
      n_fail++; $display("FAIL mid_data_active: busReq=%b required 1", ifc.busReq);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({ifc.busReq, ifc.dmemValid, ifc.stallMEM} !== 3'b001) begin
      n_fail++; $display("FAIL async_reset_drop: busReq=%b valid=%b stallMEM=%b required 0/0/1", ifc.busReq, ifc.dmemValid, ifc.stallMEM);
    end
    @(negedge clk);
    reset = 1'b0;
    slv_wait = 0;
    while (!got && lat < 20) begin
      @(negedge clk); #1; lat++;
      if (ifc.busReq === 1'b1 && ifc.busAddr === 64'h4000) addr_ok = 1;
      if (ifc.dmemValid === 1'b1) got = 1;
    end
    n_cmp++;
    if (!got || !addr_ok || lat != 2 || ifc.dmemFault !== 1'b0 || ifc.dmemRdata !== 64'h7777_6666_5555_4444) begin
      n_fail++;
      $display("FAIL regrant_after_reset: got=%0d addr_ok=%0d lat=%0d fault=%b rdata=%h required 1/1/2/0/7777666655554444",
               got, addr_ok, lat, ifc.dmemFault, ifc.dmemRdata);
    end
    ifc.dmemReq = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    bit          i_pend, d_pend, prev_i, prev_d, prev_bus, exp_done, exp_fault, issue;
    int          owner, starve;
    logic [63:0] i_addr, d_addr, d_wdata, exp_addr, exp_wdata, exp_rd;
    logic [7:0]  d_be, exp_be;
    logic        d_we, exp_we;
    i_pend = 0; d_pend = 0; prev_i = 0; prev_d = 0; prev_bus = 0; exp_done = 0; exp_fault = 0;
    owner = 0; starve = 0; i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; d_we = 0;
    exp_addr = '0; exp_wdata = '0; exp_rd = '0; exp_be = '0; exp_we = 0;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    slv_rand = 1; slv_stray = 1;
    for (int cyc = 0; cyc < 900; cyc++) begin
      issue = (cyc < 840);
      @(negedge clk); #1;
      // Completion: the cycle after the slave's ready, or after TO bus cycles.
      n_cmp++;
      if ({ifc.imemValid, ifc.dmemValid} !== {exp_done && owner == 1, exp_done && owner == 2}) begin
        n_fail++;
        $display("FAIL rand_valid: cycle %0d iv=%b dv=%b required %b%b", cyc, ifc.imemValid, ifc.dmemValid,
                 exp_done && owner == 1, exp_done && owner == 2);
      end
      if (exp_done && owner == 1) begin
        n_cmp++;
        if ({ifc.imemFault, ifc.imemRdata} !== {exp_fault, ((i_addr % 8) >= 4) ? exp_rd[63:32] : exp_rd[31:0]}) begin
          n_fail++;
          $display("FAIL rand_fetch_result: cycle %0d fault=%b rdata=%h source=%h addr=%h required fault %b",
                   cyc, ifc.imemFault, ifc.imemRdata, exp_rd, i_addr, exp_fault);
        end
      end
      if (exp_done && owner == 2) begin
        n_cmp++;
        if (ifc.dmemFault !== exp_fault || (!exp_we && ifc.dmemRdata !== exp_rd)) begin
          n_fail++;
          $display("FAIL rand_data_result: cycle %0d fault=%b rdata=%h required %b/%h (we=%b)",
                   cyc, ifc.dmemFault, ifc.dmemRdata, exp_fault, exp_rd, exp_we);
        end
      end
      if (exp_done) owner = 0;
      // Grant: data wins unless the fetch has already lost SL ties in a row.
      if (ifc.busReq === 1'b1 && !prev_bus) begin
        n_cmp++;
        if (owner != 0 || (!prev_i && !prev_d)) begin
          n_fail++;
          $display("FAIL rand_spurious_grant: cycle %0d owner=%0d ireq=%b dreq=%b", cyc, owner, prev_i, prev_d);
        end
        if (prev_i && (!prev_d || starve == SL)) begin
          owner = 1; starve = 0;
          exp_we = 1'b0; exp_addr = (i_addr / 8) * 8; exp_be = 8'hFF; exp_wdata = '0;
        end else begin
          owner = 2;
          starve = prev_i ? ((starve < SL) ? starve + 1 : SL) : 0;
          exp_we = d_we; exp_addr = d_addr; exp_be = d_be; exp_wdata = d_wdata;
        end
      end
      if (ifc.busReq === 1'b1) begin
        n_cmp++;
        if ({ifc.busWe, ifc.busAddr, ifc.busBe} !== {exp_we, exp_addr, exp_be} ||
            (exp_we && ifc.busWdata !== exp_wdata)) begin
          n_fail++;
          $display("FAIL rand_bus_fields: cycle %0d we=%b addr=%h be=%h wdata=%h required %b/%h/%h/%h",
                   cyc, ifc.busWe, ifc.busAddr, ifc.busBe, ifc.busWdata, exp_we, exp_addr, exp_be, exp_wdata);
        end
      end
      exp_done  = (ifc.busReq === 1'b1) && (ifc.busReady === 1'b1 || slv_cnt == TO);
      exp_fault = !(ifc.busReady === 1'b1);
      exp_rd    = (ifc.busReady === 1'b1) ? ifc.busRdata : 64'h0;
      prev_bus  = (ifc.busReq === 1'b1);
      // Requesters: drop after the valid, then maybe issue a fresh request.
      if (ifc.imemValid === 1'b1) i_pend = 0;
      if (ifc.dmemValid === 1'b1) d_pend = 0;
      if (issue && !i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1; i_addr = 64'($urandom_range(0, 16'hFFFF)) << 2;
      end
      if (issue && !d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_we = 1'($urandom_range(0, 1));
        d_addr = 64'($urandom_range(0, 16'hFFFF)) << 3;
        d_wdata = {$urandom, $urandom}; d_be = 8'($urandom_range(1, 255));
      end
      ifc.imemReq = i_pend; ifc.imemAddr = i_addr;
      ifc.dmemReq = d_pend; ifc.dmemWe = d_we; ifc.dmemAddr = d_addr;
      ifc.dmemWdata = d_wdata; ifc.dmemBe = d_be;
      prev_i = i_pend; prev_d = d_pend;
      #1;
      n_cmp++;
      if ({ifc.stallIF, ifc.stallMEM} !== {i_pend & ~ifc.imemValid, d_pend & ~ifc.dmemValid}) begin
        n_fail++;
        $display("FAIL rand_stall: cycle %0d stallIF=%b stallMEM=%b ireq=%b dreq=%b", cyc, ifc.stallIF, ifc.stallMEM, i_pend, d_pend);
      end
    end
    n_cmp++;
    if (i_pend || d_pend) begin
      n_fail++; $display("FAIL rand_drain: requests still pending i=%b d=%b", i_pend, d_pend);
    end
    slv_rand = 0; slv_stray = 0;
  endtask

  initial begin
    test_reset();
    test_fetch_alone();
    test_store_alone();
    test_starvation();
    test_timeout();
    test_terminal_ready();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
